// File: rtl/meas_seq_pkg.sv
// meas_seq_pkg: shared state encoding and host command codes for the measurement sequencer.
package meas_seq_pkg;
   typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, GUARD, READOUT} state_t;
   localparam logic [7:0] CMD_1M    = 8'h01;
   localparam logic [7:0] CMD_5M    = 8'h05;
   localparam logic [7:0] CMD_ABORT = 8'hFF;
endpackage

// File: rtl/sync_rise.sv
// sync_rise: two-flop synchronizer with a third flop for a one-cycle rising-edge pulse.
module sync_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);
   logic [2:0] sr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '0;
      else        sr <= {sr[1:0], d};
   assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/meas_sequencer.sv
// meas_sequencer: command-driven DA drive, AD capture and UART readout sequencer with RAM ownership.
module meas_sequencer import meas_seq_pkg::*; #(
   parameter int PRE_DLY = 50,
   parameter int CAP_TMO = 5000,
   parameter int GUARD   = 4,
   parameter int TX_TMO  = 10000000,
   parameter int CNT_W   = 24
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   input  logic       ad_done,
   input  logic       tx_done,
   output logic       da_en_1m,
   output logic       da_en_5m,
   output logic       ad_en,
   output logic       tx_en,
   output logic       ram_sel,
   output logic       busy,
   output logic       meas_done,
   output logic       err
);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_DLY - 1);
   localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAP_TMO - 1);
   localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD - 1);
   localparam logic [CNT_W-1:0] GRD_HALF = CNT_W'(GUARD / 2);
   localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_TMO - 1);
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             sel_5m, sel_5m_nx, md_nx, err_nx, drv_nx, ram_nx;
   logic             ad_done_rise, is_start, is_abort;
   sync_rise u_ad_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (ad_done),
      .rise  (ad_done_rise)
   );
   assign is_start = cmd_valid && (cmd_data == CMD_1M || cmd_data == CMD_5M);
   assign is_abort = cmd_valid && cmd_data == CMD_ABORT;
   always_comb begin
      state_nx  = state;
      sel_5m_nx = sel_5m;
      md_nx     = 1'b0;
      err_nx    = 1'b0;
      if (state == IDLE) begin
         state_nx  = is_start ? DRIVE : IDLE;
         sel_5m_nx = is_start ? (cmd_data == CMD_5M) : sel_5m;
         err_nx    = cmd_valid && !is_start && !is_abort;
      end else if (is_abort) begin
         state_nx = IDLE;
         err_nx   = 1'b1;
      end else begin
         // any other command while busy is rejected without disturbing the sequence
         err_nx = cmd_valid;
         case (state)
            DRIVE:   if (cnt == PRE_LAST) state_nx = CAPTURE;
            CAPTURE: if (ad_done_rise) state_nx = meas_seq_pkg::GUARD;
                     else if (cnt == CAP_LAST) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                     end
            meas_seq_pkg::GUARD: if (cnt == GRD_LAST) state_nx = READOUT;
            READOUT: if (tx_done) begin
                        state_nx = IDLE;
                        md_nx    = 1'b1;
                     end else if (cnt == TX_LAST) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                     end
            default: state_nx = IDLE;
         endcase
      end
      cnt_nx = (state_nx != state || state == IDLE) ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
   end
   assign drv_nx = state_nx == DRIVE || state_nx == CAPTURE;
   assign ram_nx = state_nx == READOUT || (state_nx == meas_seq_pkg::GUARD && cnt_nx >= GRD_HALF);
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_5m    <= 1'b0;
         da_en_1m  <= 1'b0;
         da_en_5m  <= 1'b0;
         ad_en     <= 1'b0;
         tx_en     <= 1'b0;
         ram_sel   <= 1'b0;
         busy      <= 1'b0;
         meas_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         sel_5m    <= sel_5m_nx;
         da_en_1m  <= drv_nx && !sel_5m_nx;
         da_en_5m  <= drv_nx && sel_5m_nx;
         ad_en     <= state_nx == CAPTURE;
         tx_en     <= state_nx == READOUT;
         ram_sel   <= ram_nx;
         busy      <= state_nx != IDLE;
         meas_done <= md_nx;
         err       <= err_nx;
      end
   end
endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer: event-time reference model of whole measurement runs, directed plus random.
module tb_meas_sequencer;
   localparam int P  = 4;
   localparam int T  = 20;
   localparam int G  = 4;
   localparam int TX = 30;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cmd_data = '0;
   logic       cmd_valid = 1'b0;
   logic       ad_done = 1'b0;
   logic       tx_done = 1'b0;
   logic       da_en_1m, da_en_5m, ad_en, tx_en, ram_sel, busy, meas_done, err;
   logic [7:0] obs;
   int         n_run = 0;
   int         n_fail = 0;
   meas_sequencer #(.PRE_DLY(P), .CAP_TMO(T), .GUARD(G), .TX_TMO(TX), .CNT_W(24)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .ad_done   (ad_done),
      .tx_done   (tx_done),
      .da_en_1m  (da_en_1m),
      .da_en_5m  (da_en_5m),
      .ad_en     (ad_en),
      .tx_en     (tx_en),
      .ram_sel   (ram_sel),
      .busy      (busy),
      .meas_done (meas_done),
      .err       (err)
   );
   always #5 clk = ~clk;
   assign obs = {da_en_1m, da_en_5m, ad_en, tx_en, ram_sel, busy, meas_done, err};
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (da1 da5 ad tx ram busy done err)", tag, got, exp);
      end
   endtask
   // d: ad_done raise offset after ad_en rise (-1 none); t: tx_done offset after tx_en rise (-1 none)
   // b: abort cycle (-1 none, -2 same cycle as tx_done, -3 random); r: rejected cmd cycle (-1 none, -3 random)
   task automatic run(input string tag, input bit m5, input int d, input int t, input int b_arg,
                      input int r_arg, input logic [7:0] rc, input int stray_arg);
      logic [7:0] e [128];
      int ar, a, ce, rd, x, ne, en, b, r, stray;
      bit cap_ok, tx_ok, ab;
      ar     = 1 + P;
      cap_ok = d >= 0;
      a      = cap_ok ? ar + d : -1;
      ce     = cap_ok ? a + 3 : ar + T;
      rd     = ce + G;
      tx_ok  = cap_ok && t >= 0;
      x      = tx_ok ? rd + t : -1;
      ne     = !cap_ok ? ce : (tx_ok ? x + 1 : rd + TX);
      b      = b_arg == -2 ? x : (b_arg == -3 ? int'($urandom_range(ne - 1, 1)) : b_arg);
      ab     = b >= 1 && b < ne;
      en     = ab ? b + 1 : ne;
      r      = r_arg == -3 ? int'($urandom_range(en - 1, 1)) : r_arg;
      if (r < 1 || r >= en || (ab && r == b)) r = -1;
      stray  = stray_arg == -3 ? int'($urandom_range((cap_ok ? rd : ce) - 1, 0)) : stray_arg;
      for (int j = 0; j <= en + 3; j++) begin
         logic [7:0] v;
         v = '0;
         if (j >= 1 && j < en) begin
            v[2] = 1'b1;
            if (j < ce) v[m5 ? 6 : 7] = 1'b1;
            if (j >= ar && j < ce) v[5] = 1'b1;
            if (cap_ok && j >= rd) v[4] = 1'b1;
            if (cap_ok && j >= ce + G / 2) v[3] = 1'b1;
         end
         if (j == en) begin
            v[1] = !ab && tx_ok;
            v[0] = ab || !tx_ok;
         end
         if (r >= 0 && j == r + 1) v[0] = 1'b1;
         e[j] = v;
      end
      for (int j = 0; j <= en + 3; j++) begin
         cmd_valid = j == 0 || (ab && j == b) || j == r;
         cmd_data  = j == 0 ? (m5 ? 8'h05 : 8'h01) : ((ab && j == b) ? 8'hFF : (j == r ? rc : 8'h00));
         ad_done   = cap_ok && j >= a && j < (ce < en ? ce : en);
         tx_done   = (tx_ok && j == x) || j == stray;
         @(negedge clk);
         chk($sformatf("%s@%0d", tag, j), obs, e[j]);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      cmd_data  = '0;
      ad_done   = 1'b0;
      tx_done   = 1'b0;
   endtask
   task automatic idle_cmd(input string tag, input logic [7:0] code, input bit exp_err);
      for (int j = 0; j < 3; j++) begin
         cmd_valid = j == 0;
         cmd_data  = j == 0 ? code : 8'h00;
         @(negedge clk);
         chk($sformatf("%s@%0d", tag, j), obs, (j == 1 && exp_err) ? 8'h01 : 8'h00);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset", obs, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run("normal_1m", 1'b0, 6, 10, -1, -1, 8'h00, -1);
      run("timeout_5m", 1'b1, -1, 0, -1, -1, 8'h00, -1);
      run("abort_tx", 1'b0, 6, 10, -2, -1, 8'h00, -1);
      run("reject_busy", 1'b1, 6, 10, -1, 1 + P + 2, 8'h05, -1);
      idle_cmd("reject_idle", 8'h3C, 1'b1);
      idle_cmd("abort_idle", 8'hFF, 1'b0);
      run("tx_timeout", 1'b0, 3, -1, -1, -1, 8'h00, 2);
      cmd_valid = 1'b1;
      cmd_data  = 8'h01;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #3;
      chk("pre_reset", obs, 8'h84);
      rst_n = 1'b0;
      #1;
      chk("async_reset", obs, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run("after_reset", 1'b0, 6, 10, -1, -1, 8'h00, -1);
      for (int i = 0; i < 40; i++) begin
         int k;
         k = int'($urandom_range(2, 0));
         run($sformatf("rnd%0d", i), 1'(($urandom_range(1, 0))),
             $urandom_range(4, 0) == 0 ? -1 : int'($urandom_range(15, 0)),
             $urandom_range(4, 0) == 0 ? -1 : int'($urandom_range(25, 0)),
             $urandom_range(9, 0) < 3 ? -3 : -1,
             $urandom_range(9, 0) < 3 ? -3 : -1,
             k == 0 ? 8'h01 : (k == 1 ? 8'h05 : 8'h3C),
             $urandom_range(9, 0) < 3 ? -3 : -1);
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
